// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: per-car sequencer owning floor position, travel direction
// and door timing. Serves hall calls (up_call/down_call) and car calls, and
// issues single-cycle one-hot clear pulses for each call it serves.
// Optional build macro ELEV_DOOR_HOLD_EN adds a door_hold input that freezes
// the door timer while asserted in the DOOR state.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS  = 7,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_FLOORS-1:0] up_call,
  input  logic [NUM_FLOORS-1:0] down_call,
  input  logic [NUM_FLOORS-1:0] car_call,
  input  logic                  turn_req,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [FLOOR_W-1:0]    curr_floor,
  output logic                  dir,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] clr_up,
  output logic [NUM_FLOORS-1:0] clr_down,
  output logic [NUM_FLOORS-1:0] clr_car
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_DOOR = 2'd2;

  localparam int MC_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DC_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [MC_W-1:0]       MC_LAST   = MC_W'(MOVE_CYCLES - 1);
  localparam logic [DC_W-1:0]       DC_LAST   = DC_W'(DOOR_CYCLES - 1);
  localparam logic [MC_W-1:0]       MC_ZERO   = {MC_W{1'b0}};
  localparam logic [DC_W-1:0]       DC_ZERO   = {DC_W{1'b0}};
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]    BOT_FLOOR = {FLOOR_W{1'b0}};
  localparam logic [NUM_FLOORS-1:0] NO_BITS   = {NUM_FLOORS{1'b0}};

  // Value of vec at floor f; floors outside the vector read as 0.
  function automatic logic bit_at(input logic [NUM_FLOORS-1:0] vec,
                                  input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      r = r | ((FLOOR_W'(i) == f) & vec[i]);
    end
    return r;
  endfunction

  // One-hot vector selecting floor f.
  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] v;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      v[i] = (FLOOR_W'(i) == f);
    end
    return v;
  endfunction

  // Any bit of vec strictly above f (d=1) or strictly below f (d=0).
  function automatic logic calls_beyond(input logic [NUM_FLOORS-1:0] vec,
                                        input logic [FLOOR_W-1:0]    f,
                                        input logic                  d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      r = r | (vec[i] & (d ? (FLOOR_W'(i) > f) : (FLOOR_W'(i) < f)));
    end
    return r;
  endfunction

  // The top floor can only head down and the bottom floor only up.
  function automatic logic force_dir(input logic [FLOOR_W-1:0] f, input logic d);
    logic r;
    if (f == TOP_FLOOR) begin
      r = 1'b0;
    end else if (f == BOT_FLOOR) begin
      r = 1'b1;
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic [1:0]            state, state_nxt;
  logic [MC_W-1:0]       mcnt, mcnt_nxt;
  logic [DC_W-1:0]       dcnt, dcnt_nxt;
  logic                  restarted, restarted_nxt;
  logic [FLOOR_W-1:0]    floor_nxt;
  logic                  dir_nxt, arrive_nxt;
  logic [NUM_FLOORS-1:0] clr_up_nxt, clr_down_nxt, clr_car_nxt;

  logic [NUM_FLOORS-1:0] all_calls;
  logic                  here_up, here_dn, here_car, here_any;
  logic                  ahead, behind;
  logic                  new_up, new_dn, new_car, new_any;
  logic [NUM_FLOORS-1:0] oh_here, oh_arr;
  logic                  step_ok;
  logic [FLOOR_W-1:0]    arr_floor;
  logic                  arr_dir, arr_up, arr_dn, arr_car, arr_here, arr_ahead;
  logic                  hold;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  assign all_calls = up_call | down_call | car_call;

  // Request terms at the current floor in the current direction.
  assign here_up  = dir & bit_at(up_call, curr_floor);
  assign here_dn  = ~dir & bit_at(down_call, curr_floor);
  assign here_car = bit_at(car_call, curr_floor);
  assign here_any = here_up | here_dn | here_car;
  assign ahead    = calls_beyond(all_calls, curr_floor, dir);
  assign behind   = calls_beyond(all_calls, curr_floor, ~dir);
  assign oh_here  = onehot(curr_floor);

  // A call is new during DOOR only if its clear is not already on the wire,
  // so a requester that takes one cycle to drop the call is not re-served.
  assign new_up  = here_up & ~bit_at(clr_up, curr_floor);
  assign new_dn  = here_dn & ~bit_at(clr_down, curr_floor);
  assign new_car = here_car & ~bit_at(clr_car, curr_floor);
  assign new_any = new_up | new_dn | new_car;

  // Terms evaluated at the floor being arrived at, with boundary forcing.
  assign step_ok   = dir ? (curr_floor != TOP_FLOOR) : (curr_floor != BOT_FLOOR);
  assign arr_floor = dir ? (curr_floor + FLOOR_W'(1)) : (curr_floor - FLOOR_W'(1));
  assign arr_dir   = force_dir(arr_floor, dir);
  assign arr_up    = arr_dir & bit_at(up_call, arr_floor);
  assign arr_dn    = ~arr_dir & bit_at(down_call, arr_floor);
  assign arr_car   = bit_at(car_call, arr_floor);
  assign arr_here  = arr_up | arr_dn | arr_car;
  assign arr_ahead = calls_beyond(all_calls, arr_floor, arr_dir);
  assign oh_arr    = onehot(arr_floor);

  // Next-state logic for the IDLE / MOVE / DOOR sequencer.
  always_comb begin
    state_nxt     = state;
    floor_nxt     = curr_floor;
    dir_nxt       = dir;
    mcnt_nxt      = mcnt;
    dcnt_nxt      = dcnt;
    restarted_nxt = restarted;
    arrive_nxt    = 1'b0;
    clr_up_nxt    = NO_BITS;
    clr_down_nxt  = NO_BITS;
    clr_car_nxt   = NO_BITS;
    case (state)
      ST_IDLE: begin
        if (here_any) begin
          state_nxt     = ST_DOOR;
          dcnt_nxt      = DC_ZERO;
          restarted_nxt = 1'b0;
          clr_up_nxt    = here_up  ? oh_here : NO_BITS;
          clr_down_nxt  = here_dn  ? oh_here : NO_BITS;
          clr_car_nxt   = here_car ? oh_here : NO_BITS;
        end else if (ahead) begin
          state_nxt = ST_MOVE;
          mcnt_nxt  = MC_ZERO;
        end else if (turn_req | behind) begin
          dir_nxt = force_dir(curr_floor, ~dir);
        end else begin
          dir_nxt = force_dir(curr_floor, dir);
        end
      end
      ST_MOVE: begin
        if (mcnt != MC_LAST) begin
          mcnt_nxt = mcnt + MC_W'(1);
        end else if (!step_ok) begin
          // Never travel past either end of the shaft.
          state_nxt = ST_IDLE;
          mcnt_nxt  = MC_ZERO;
          dir_nxt   = force_dir(curr_floor, dir);
        end else begin
          floor_nxt  = arr_floor;
          dir_nxt    = arr_dir;
          arrive_nxt = 1'b1;
          mcnt_nxt   = MC_ZERO;
          if (arr_here) begin
            state_nxt     = ST_DOOR;
            dcnt_nxt      = DC_ZERO;
            restarted_nxt = 1'b0;
            clr_up_nxt    = arr_up  ? oh_arr : NO_BITS;
            clr_down_nxt  = arr_dn  ? oh_arr : NO_BITS;
            clr_car_nxt   = arr_car ? oh_arr : NO_BITS;
          end else if (arr_ahead) begin
            state_nxt = ST_MOVE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        clr_up_nxt   = new_up  ? oh_here : NO_BITS;
        clr_down_nxt = new_dn  ? oh_here : NO_BITS;
        clr_car_nxt  = new_car ? oh_here : NO_BITS;
        if (new_any & ~restarted) begin
          dcnt_nxt      = DC_ZERO;
          restarted_nxt = 1'b1;
        end else if (hold) begin
          dcnt_nxt = dcnt;
        end else if (dcnt != DC_LAST) begin
          dcnt_nxt = dcnt + DC_W'(1);
        end else begin
          state_nxt = ST_IDLE;
          dir_nxt   = force_dir(curr_floor, dir ^ turn_req);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        mcnt_nxt  = MC_ZERO;
        dcnt_nxt  = DC_ZERO;
      end
    endcase
  end

  // State and output registers; enable=0 freezes everything but the pulses,
  // which drop so a clear is never stretched or replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      curr_floor <= BOT_FLOOR;
      dir        <= 1'b1;
      mcnt       <= MC_ZERO;
      dcnt       <= DC_ZERO;
      restarted  <= 1'b0;
      moving     <= 1'b0;
      door_open  <= 1'b0;
      arrive     <= 1'b0;
      clr_up     <= NO_BITS;
      clr_down   <= NO_BITS;
      clr_car    <= NO_BITS;
    end else if (enable) begin
      state      <= state_nxt;
      curr_floor <= floor_nxt;
      dir        <= dir_nxt;
      mcnt       <= mcnt_nxt;
      dcnt       <= dcnt_nxt;
      restarted  <= restarted_nxt;
      moving     <= (state_nxt == ST_MOVE);
      door_open  <= (state_nxt == ST_DOOR);
      arrive     <= arrive_nxt;
      clr_up     <= clr_up_nxt;
      clr_down   <= clr_down_nxt;
      clr_car    <= clr_car_nxt;
    end else begin
      arrive   <= 1'b0;
      clr_up   <= NO_BITS;
      clr_down <= NO_BITS;
      clr_car  <= NO_BITS;
    end
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Self-checking bench for elevator_car_ctrl: directed scenarios followed by
// randomized calls, all compared each cycle against a behavioural car model.
module tb_elevator_car_ctrl;
  localparam int NF = 7;
  localparam int MOVE = 4;
  localparam int DOOR = 3;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic clk = 1'b0;
  logic rst_n, enable, turn_req, door_hold;
  logic [NF-1:0] up_call, down_call, car_call;
  logic [2:0] curr_floor;
  logic dir, moving, door_open, arrive;
  logic [NF-1:0] clr_up, clr_down, clr_car;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  int m_floor, m_mode, m_left;
  bit m_up, m_restart, m_arrive;
  bit [NF-1:0] m_cu, m_cd, m_cc;

  // collected statistics for directed scenarios
  int n_arr, door_n, arr_t[8];
  bit dir_last_arr;
  logic [NF-1:0] or_up, or_down, or_car;

  always #5 clk = ~clk;

  elevator_car_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .up_call(up_call), .down_call(down_call), .car_call(car_call),
    .turn_req(turn_req),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .curr_floor(curr_floor), .dir(dir), .moving(moving), .door_open(door_open),
    .arrive(arrive), .clr_up(clr_up), .clr_down(clr_down), .clr_car(clr_car)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit here_at(int f, bit up);
    return car_call[f] | (up ? up_call[f] : down_call[f]);
  endfunction

  function automatic bit any_beyond(int f, bit up);
    bit r = 1'b0;
    for (int i = 0; i < NF; i++)
      if (up ? (i > f) : (i < f)) r |= up_call[i] | down_call[i] | car_call[i];
    return r;
  endfunction

  function automatic bit pinned(int f, bit up);
    if (f == NF - 1) return 1'b0;
    if (f == 0) return 1'b1;
    return up;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_up = 1'b1; m_mode = M_IDLE; m_left = 0;
    m_restart = 1'b0; m_arrive = 1'b0; m_cu = '0; m_cd = '0; m_cc = '0;
  endtask

  task automatic open_door();
    m_mode = M_DOOR; m_left = DOOR; m_restart = 1'b0;
    if (m_up && up_call[m_floor]) m_cu[m_floor] = 1'b1;
    if (!m_up && down_call[m_floor]) m_cd[m_floor] = 1'b1;
    if (car_call[m_floor]) m_cc[m_floor] = 1'b1;
  endtask

  task automatic model_step();
    bit [NF-1:0] pu, pd, pc;
    bit nu, nd, nc;
    pu = m_cu; pd = m_cd; pc = m_cc;
    m_arrive = 1'b0; m_cu = '0; m_cd = '0; m_cc = '0;
    if (!enable) return;
    case (m_mode)
      M_IDLE: begin
        if (here_at(m_floor, m_up)) open_door();
        else if (any_beyond(m_floor, m_up)) begin m_mode = M_MOVE; m_left = MOVE; end
        else begin
          if (turn_req || any_beyond(m_floor, !m_up)) m_up = !m_up;
          m_up = pinned(m_floor, m_up);
        end
      end
      M_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_up ? 1 : -1;
          m_arrive = 1'b1;
          m_up = pinned(m_floor, m_up);
          if (here_at(m_floor, m_up)) open_door();
          else if (any_beyond(m_floor, m_up)) m_left = MOVE;
          else m_mode = M_IDLE;
        end
      end
      M_DOOR: begin
        nu = m_up && up_call[m_floor] && !pu[m_floor];
        nd = !m_up && down_call[m_floor] && !pd[m_floor];
        nc = car_call[m_floor] && !pc[m_floor];
        m_cu[m_floor] = nu; m_cd[m_floor] = nd; m_cc[m_floor] = nc;
        if ((nu || nd || nc) && !m_restart) begin m_left = DOOR; m_restart = 1'b1; end
        else if (!door_hold) begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE;
            if (turn_req) m_up = !m_up;
            m_up = pinned(m_floor, m_up);
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("floor", 32'(curr_floor), 32'(m_floor));
    chk("dir", 32'(dir), 32'(m_up));
    chk("moving", 32'(moving), 32'(m_mode == M_MOVE));
    chk("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
    chk("arrive", 32'(arrive), 32'(m_arrive));
    chk("clr_up", 32'(clr_up), 32'(m_cu));
    chk("clr_down", 32'(clr_down), 32'(m_cd));
    chk("clr_car", 32'(clr_car), 32'(m_cc));
  endtask

  // One clock: model advances with the DUT edge, compare mid-cycle, then the
  // call sources drop whatever the car is expected to have served.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
    up_call &= ~m_cu; down_call &= ~m_cd; car_call &= ~m_cc;
  endtask

  task automatic run_collect(input int n);
    n_arr = 0; door_n = 0; or_up = '0; or_down = '0; or_car = '0; dir_last_arr = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc();
      if (arrive === 1'b1) begin
        if (n_arr < 8) arr_t[n_arr] = k;
        n_arr++;
        dir_last_arr = dir;
      end
      if (door_open === 1'b1) door_n++;
      or_up |= clr_up; or_down |= clr_down; or_car |= clr_car;
    end
  endtask

  initial begin
    int t, pulses;
    bit rep2;
    rst_n = 1'b0; enable = 1'b1; turn_req = 1'b0; door_hold = 1'b0;
    up_call = '0; down_call = '0; car_call = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    chk("rst_floor", 32'(curr_floor), 32'd0);
    chk("rst_dir", 32'(dir), 32'd1);
    rst_n = 1'b1;

    // 1: car call to floor 3 from reset
    car_call = 7'b0001000;
    run_collect(25);
    chk("t1_arrivals", n_arr, 32'd3);
    chk("t1_arr0", arr_t[0], 32'd4);
    chk("t1_arr1", arr_t[1], 32'd8);
    chk("t1_arr2", arr_t[2], 32'd12);
    chk("t1_door_cycles", door_n, 32'd3);
    chk("t1_clr_car", 32'(or_car), 32'h08);
    chk("t1_floor", 32'(curr_floor), 32'd3);

    // 2: down call behind the car reverses it
    down_call = 7'b0000010;
    run_collect(25);
    chk("t2_clr_down", 32'(or_down), 32'h02);
    chk("t2_floor", 32'(curr_floor), 32'd1);
    chk("t2_dir", 32'(dir), 32'd0);
    chk("t2_arrivals", n_arr, 32'd2);

    // 3: from floor 0, up call at the top floor
    car_call = 7'b0000001;
    run_collect(15);
    chk("t3_start_floor", 32'(curr_floor), 32'd0);
    chk("t3_start_dir", 32'(dir), 32'd1);
    up_call = 7'b1000000;
    run_collect(35);
    chk("t3_arrivals", n_arr, 32'd6);
    chk("t3_floor", 32'(curr_floor), 32'd6);
    chk("t3_dir_on_arrive", 32'(dir_last_arr), 32'd0);
    chk("t3_no_clr_up", 32'(or_up), 32'd0);
    chk("t3_no_door", door_n, 32'd0);
    up_call = '0;

    // 4: up call repeated during DOOR at floor 2 going up
    car_call = 7'b0000001;
    run_collect(40);
    car_call = 7'b0000100;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (door_open === 1'b1) break;
    end
    chk("t4_door_reached", 32'(door_open), 32'd1);
    chk("t4_floor", 32'(curr_floor), 32'd2);
    chk("t4_dir", 32'(dir), 32'd1);
    cyc();
    chk("t4_door_c2", 32'(door_open), 32'd1);
    door_n = 2; pulses = 0; rep2 = 1'b0;
    up_call[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (door_open === 1'b1) door_n++;
      if (clr_up[2] === 1'b1) pulses++;
      if (door_n == 4 && !rep2) begin up_call[2] = 1'b1; rep2 = 1'b1; end
    end
    chk("t4_door_total", door_n, 32'd5);
    chk("t4_clr_up_pulses", pulses, 32'd2);

    // 5: freeze for 5 cycles mid-travel
    car_call = 7'b0100000;
    repeat (6) cyc();
    chk("t5_mid_floor", 32'(curr_floor), 32'd3);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t5_frozen_floor", 32'(curr_floor), 32'd3);
      chk("t5_frozen_moving", 32'(moving), 32'd1);
    end
    enable = 1'b1;
    t = 11;
    for (int k = 0; k < 30; k++) begin
      cyc();
      t++;
      if (door_open === 1'b1) break;
    end
    chk("t5_travel_cycles", t, 32'd18);
    chk("t5_floor", 32'(curr_floor), 32'd5);

    // 6: reset while moving at floor 4
    car_call = '0;
    run_collect(5);
    car_call = 7'b0000001;
    repeat (7) cyc();
    chk("t6_pre_floor", 32'(curr_floor), 32'd4);
    chk("t6_pre_moving", 32'(moving), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_floor", 32'(curr_floor), 32'd0);
    chk("t6_rst_dir", 32'(dir), 32'd1);
    chk("t6_rst_moving", 32'(moving), 32'd0);
    chk("t6_rst_door", 32'(door_open), 32'd0);
    chk("t6_rst_clr", 32'({clr_up, clr_down, clr_car, arrive}), 32'd0);
    model_reset();
    car_call = '0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ELEV_DOOR_HOLD_EN
    // door_hold keeps the door open beyond the timer
    car_call = 7'b0000001;
    cyc();
    chk("hold_door_open", 32'(door_open), 32'd1);
    door_n = 1;
    door_hold = 1'b1;
    for (int k = 0; k < 10; k++) begin cyc(); if (door_open === 1'b1) door_n++; end
    door_hold = 1'b0;
    for (int k = 0; k < 8; k++) begin cyc(); if (door_open === 1'b1) door_n++; end
    chk("hold_door_cycles", door_n, 32'd13);
`endif

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        int idx;
        idx = $urandom_range(0, NF - 1);
        case ($urandom_range(0, 2))
          0: up_call[idx] = 1'b1;
          1: down_call[idx] = 1'b1;
          default: car_call[idx] = 1'b1;
        endcase
      end
      turn_req = ($urandom_range(0, 15) == 0);
      enable = ($urandom_range(0, 9) != 0);
`ifdef ELEV_DOOR_HOLD_EN
      door_hold = ($urandom_range(0, 7) == 0);
`endif
      if (k == 1500) begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
